// File: rtl/wishbone_ram_target_if.sv
// Pipelined Wishbone bus bundle between an initiator (master) and the RAM target (slave).
interface wishbone_ram_target_if #(
  parameter int AddressWidth = 16,
  parameter int DataWidth    = 32,
  parameter int Granularity  = 8,
  parameter int TGAWidth     = 1,
  parameter int TGCWidth     = 1,
  parameter int TGDWidth     = 1
);
  localparam int SELWidth = DataWidth / Granularity;

  logic                    CYC;
  logic                    STB;
  logic                    WE;
  logic                    LOCK;
  logic [2:0]              CTI;
  logic [1:0]              BTE;
  logic [AddressWidth-1:0] ADDR;
  logic [SELWidth-1:0]     SEL;
  logic [DataWidth-1:0]    DAT_ToTarget;
  logic [TGAWidth-1:0]     TGA;
  logic [TGCWidth-1:0]     TGC;
  logic [TGDWidth-1:0]     TGD_ToTarget;
  logic [DataWidth-1:0]    DAT_ToInitiator;
  logic                    ACK;
  logic                    ERR;
  logic                    RTY;
  logic                    STALL;
  logic [TGDWidth-1:0]     TGD_ToInitiator;

  modport master (
    output CYC, STB, WE, LOCK, CTI, BTE, ADDR, SEL, DAT_ToTarget, TGA, TGC, TGD_ToTarget,
    input  DAT_ToInitiator, ACK, ERR, RTY, STALL, TGD_ToInitiator
  );

  modport slave (
    input  CYC, STB, WE, LOCK, CTI, BTE, ADDR, SEL, DAT_ToTarget, TGA, TGC, TGD_ToTarget,
    output DAT_ToInitiator, ACK, ERR, RTY, STALL, TGD_ToInitiator
  );
endinterface

// File: rtl/wishbone_ram_target.sv
// Pipelined Wishbone RAM target: ACK/ERR at 1+WaitStates cycles after accept.
// STALL is raised only while counting wait states; one transfer per 1+WaitStates cycles.
module wishbone_ram_target #(
  parameter int AddressWidth = 16,
  parameter int DataWidth    = 32,
  parameter int Granularity  = 8,
  parameter int Depth        = 1024,
  parameter int WaitStates   = 0
) (
  input logic CLK,
  input logic RST,
  wishbone_ram_target_if.slave bus
);
  localparam int SELWidth = DataWidth / Granularity;
  localparam int IdxWidth = (Depth > 1) ? $clog2(Depth) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t               r_state;
  logic [3:0]           r_cnt;
  logic                 r_ack;
  logic                 r_err;
  logic                 r_stall;
  logic [DataWidth-1:0] r_dat;
  logic [DataWidth-1:0] r_pend_dat;
  logic                 r_pend_err;
  logic [DataWidth-1:0] r_mem [Depth];

  logic                 w_accept;
  logic                 w_in_range;
  logic [IdxWidth-1:0]  w_idx;
  logic [DataWidth-1:0] w_rd;
  logic                 w_unused;

  assign w_accept   = bus.CYC && bus.STB && !r_stall && !RST;
  assign w_in_range = ({1'b0, bus.ADDR} < (AddressWidth + 1)'(Depth));
  assign w_idx      = bus.ADDR[IdxWidth-1:0];
  // Reads of a write or of an unmapped word return zero on the bus.
  assign w_rd       = (w_in_range && !bus.WE) ? r_mem[w_idx] : '0;
  assign w_unused   = ^{bus.LOCK, bus.CTI, bus.BTE, bus.TGA, bus.TGC, bus.TGD_ToTarget};

  always_ff @(posedge CLK) begin
    if (w_accept && bus.WE && w_in_range) begin
      for (int i = 0; i < SELWidth; i++) begin
        if (bus.SEL[i]) begin
          r_mem[w_idx][i*Granularity +: Granularity] <= bus.DAT_ToTarget[i*Granularity +: Granularity];
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_stall    <= 1'b0;
      r_dat      <= '0;
      r_pend_dat <= '0;
      r_pend_err <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      r_err <= 1'b0;
      r_dat <= '0;
      case (r_state)
        IDLE, RESP: begin
          if (w_accept) begin
            r_pend_dat <= w_rd;
            r_pend_err <= !w_in_range;
            if (WaitStates == 0) begin
              r_state <= RESP;
              r_ack   <= w_in_range;
              r_err   <= !w_in_range;
              r_dat   <= w_rd;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 4'(WaitStates - 1);
              r_stall <= 1'b1;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        WAIT: begin
          // Dropping CYC abandons the transfer; any write has already landed.
          if (!bus.CYC) begin
            r_state <= IDLE;
            r_stall <= 1'b0;
          end else if (r_cnt == '0) begin
            r_state <= RESP;
            r_stall <= 1'b0;
            r_ack   <= !r_pend_err;
            r_err   <= r_pend_err;
            r_dat   <= r_pend_dat;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  // Termination is masked by CYC so an abort in the response cycle issues nothing.
  assign bus.ACK             = r_ack && bus.CYC;
  assign bus.ERR             = r_err && bus.CYC;
  assign bus.DAT_ToInitiator = (r_ack && bus.CYC) ? r_dat : '0;
  assign bus.RTY             = 1'b0;
  assign bus.STALL           = r_stall;
  assign bus.TGD_ToInitiator = '0;
endmodule

// File: tb/tb_wishbone_ram_target.sv
// Bench for wishbone_ram_target: two instances (WaitStates 0 and 3) against an array memory model.
module tb_wishbone_ram_target;
  localparam int AW    = 16;
  localparam int DW    = 32;
  localparam int DEPTH = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst   [2];
  logic          cyc   [2];
  logic          stb   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [3:0]    sel   [2];
  logic [DW-1:0] wdat  [2];
  logic          ack   [2];
  logic          err   [2];
  logic          rty   [2];
  logic          stall [2];
  logic [DW-1:0] rdat  [2];
  logic          tgd   [2];
  logic [7:0]    junk;

  logic [31:0] ref_mem [2][DEPTH];
  int checks   = 0;
  int failures = 0;

  wishbone_ram_target_if #(.AddressWidth(AW), .DataWidth(DW), .Granularity(8)) bus0 ();
  wishbone_ram_target_if #(.AddressWidth(AW), .DataWidth(DW), .Granularity(8)) bus3 ();

  assign bus0.CYC = cyc[0];  assign bus3.CYC = cyc[1];
  assign bus0.STB = stb[0];  assign bus3.STB = stb[1];
  assign bus0.WE  = we[0];   assign bus3.WE  = we[1];
  assign bus0.ADDR = addr[0]; assign bus3.ADDR = addr[1];
  assign bus0.SEL  = sel[0];  assign bus3.SEL  = sel[1];
  assign bus0.DAT_ToTarget = wdat[0]; assign bus3.DAT_ToTarget = wdat[1];
  assign bus0.LOCK = junk[0]; assign bus3.LOCK = junk[0];
  assign bus0.CTI  = junk[3:1]; assign bus3.CTI = junk[3:1];
  assign bus0.BTE  = junk[5:4]; assign bus3.BTE = junk[5:4];
  assign bus0.TGA  = junk[6]; assign bus3.TGA = junk[6];
  assign bus0.TGC  = junk[7]; assign bus3.TGC = junk[7];
  assign bus0.TGD_ToTarget = junk[2]; assign bus3.TGD_ToTarget = junk[2];
  assign ack[0] = bus0.ACK;   assign ack[1] = bus3.ACK;
  assign err[0] = bus0.ERR;   assign err[1] = bus3.ERR;
  assign rty[0] = bus0.RTY;   assign rty[1] = bus3.RTY;
  assign stall[0] = bus0.STALL; assign stall[1] = bus3.STALL;
  assign rdat[0] = bus0.DAT_ToInitiator; assign rdat[1] = bus3.DAT_ToInitiator;
  assign tgd[0] = bus0.TGD_ToInitiator;  assign tgd[1] = bus3.TGD_ToInitiator;

  wishbone_ram_target #(.AddressWidth(AW), .DataWidth(DW), .Granularity(8), .Depth(DEPTH), .WaitStates(0))
    u_dut0 (.CLK(clk), .RST(rst[0]), .bus(bus0));
  wishbone_ram_target #(.AddressWidth(AW), .DataWidth(DW), .Granularity(8), .Depth(DEPTH), .WaitStates(3))
    u_dut3 (.CLK(clk), .RST(rst[1]), .bus(bus3));

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] m;
    m = old;
    for (int i = 0; i < 4; i++) if (s[i]) m[i*8 +: 8] = nw[i*8 +: 8];
    return m;
  endfunction

  function automatic logic [AW-1:0] pick_addr();
    int r;
    r = $urandom_range(0, 39);
    if (r < 32)       return AW'(r);
    else if (r == 32) return AW'(976);
    else if (r == 33) return AW'(1023);
    else if (r < 36)  return AW'(DEPTH + $urandom_range(0, 60000));
    else              return AW'($urandom_range(0, 31));
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One complete transfer: present, wait for accept, wait for termination, then release the bus.
  task automatic xfer(input int d, input logic w, input logic [AW-1:0] a, input logic [3:0] s,
                      input logic [31:0] dat, input string tag, output logic [31:0] rd_out);
    bit          acc;
    bit          oor;
    int          lat;
    logic        g_ack, g_err, g_rty;
    logic [31:0] g_dat, exp;
    oor = (int'(a) >= DEPTH);
    exp = (w || oor) ? 32'h0 : ref_mem[d][a];
    @(negedge clk);
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; addr[d] = a; sel[d] = s; wdat[d] = dat;
    junk = 8'($urandom);
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) begin
      if (!stall[d]) acc = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_accept"}, 64'(acc), 64'd1);
    if (w && !oor) ref_mem[d][a] = merge(ref_mem[d][a], dat, s);
    lat = 0; g_ack = 1'b0; g_err = 1'b0; g_rty = 1'b0; g_dat = 32'h0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      g_ack = ack[d]; g_err = err[d]; g_rty = rty[d]; g_dat = rdat[d];
      stb[d] = 1'b0;
      if (g_ack || g_err) begin
        lat = i;
        break;
      end
    end
    check({tag, "_latency"}, 64'(lat), 64'(1 + ws_of(d)));
    check({tag, "_ack"}, 64'(g_ack), 64'(!oor));
    check({tag, "_err"}, 64'(g_err), 64'(oor));
    check({tag, "_rty"}, 64'(g_rty), 64'd0);
    check({tag, "_data"}, 64'(g_dat), 64'(exp));
    @(negedge clk);
    check({tag, "_single_term"}, 64'(ack[d] | err[d]), 64'd0);
    cyc[d] = 1'b0;
    rd_out = g_dat;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] keep;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; cyc[d] = 1'b1; stb[d] = 1'b0; we[d] = 1'b0;
      addr[d] = '0; sel[d] = '0; wdat[d] = '0;
    end
    junk = 8'h0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check("rst_stall", 64'(stall[d]), 64'd0);
      check("rst_ack", 64'(ack[d]), 64'd0);
      check("rst_err", 64'(err[d]), 64'd0);
      check("rst_rty", 64'(rty[d]), 64'd0);
      check("rst_dat", 64'(rdat[d]), 64'd0);
      check("rst_tgd", 64'(tgd[d]), 64'd0);
      rst[d] = 1'b0; cyc[d] = 1'b0;
    end

    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 34; a++) begin
        int aa;
        aa = (a < 32) ? a : ((a == 32) ? 976 : 1023);
        xfer(d, 1'b1, AW'(aa), 4'hF, $urandom, "prefill", rd);
      end
    end

    // Back-to-back write then read of word 5 with no wait states.
    @(negedge clk);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'd5; sel[0] = 4'hF; wdat[0] = 32'hDEADBEEF;
    @(negedge clk);
    check("b2b_wr_ack", 64'(ack[0]), 64'd1);
    check("b2b_wr_dat", 64'(rdat[0]), 64'd0);
    we[0] = 1'b0;
    @(negedge clk);
    check("b2b_rd_ack", 64'(ack[0]), 64'd1);
    check("b2b_rd_dat", 64'(rdat[0]), 64'hDEADBEEF);
    stb[0] = 1'b0;
    @(negedge clk);
    check("b2b_idle_ack", 64'(ack[0]), 64'd0);
    cyc[0] = 1'b0;
    ref_mem[0][5] = 32'hDEADBEEF;

    xfer(0, 1'b1, 16'd5, 4'b0101, 32'h11223344, "lane_wr", rd);
    xfer(0, 1'b0, 16'd5, 4'b0000, 32'h0, "lane_rd", rd);
    check("lane_const", 64'(rd), 64'hDE22BE44);
    xfer(0, 1'b1, 16'd6, 4'b0000, 32'hFFFFFFFF, "sel0_wr", rd);
    xfer(0, 1'b0, 16'd6, 4'b1111, 32'h0, "sel0_rd", rd);

    // Wait-state pipeline: second request held during STALL is taken on the ACK cycle.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'd7; sel[1] = 4'hF;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("ws3_stall", 64'(stall[1]), 64'd1);
      check("ws3_noack", 64'(ack[1]), 64'd0);
      addr[1] = 16'd8;
    end
    @(negedge clk);
    check("ws3_ack", 64'(ack[1]), 64'd1);
    check("ws3_stall_resp", 64'(stall[1]), 64'd0);
    check("ws3_dat1", 64'(rdat[1]), 64'(ref_mem[1][7]));
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      check("ws3_stall2", 64'(stall[1]), 64'd1);
      stb[1] = 1'b0;
    end
    @(negedge clk);
    check("ws3_ack2", 64'(ack[1]), 64'd1);
    check("ws3_dat2", 64'(rdat[1]), 64'(ref_mem[1][8]));
    cyc[1] = 1'b0;

    xfer(0, 1'b0, 16'd1024, 4'hF, 32'h0, "oor_rd", rd);
    xfer(0, 1'b1, 16'd2000, 4'hF, 32'h5A5A5A5A, "oor_wr", rd);
    xfer(0, 1'b0, 16'd976, 4'hF, 32'h0, "alias_rd", rd);

    // Abort during WAIT: the write stays, no termination is issued.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; addr[1] = 16'd9; sel[1] = 4'hF; wdat[1] = 32'hCAFEF00D;
    ref_mem[1][9] = 32'hCAFEF00D;
    @(negedge clk);
    check("abort_stall", 64'(stall[1]), 64'd1);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'(stall[1]), 64'd0);
    cyc[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("abort_noterm", 64'(ack[1] | err[1]), 64'd0);
    end
    cyc[1] = 1'b0;
    xfer(1, 1'b0, 16'd9, 4'h0, 32'h0, "abort_rd", rd);

    // Reset pulse while waiting.
    @(negedge clk);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'd10;
    @(negedge clk);
    stb[1] = 1'b0; rst[1] = 1'b1;
    @(negedge clk);
    check("rstw_ack", 64'(ack[1]), 64'd0);
    check("rstw_err", 64'(err[1]), 64'd0);
    check("rstw_stall", 64'(stall[1]), 64'd0);
    check("rstw_dat", 64'(rdat[1]), 64'd0);
    rst[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rstw_noterm", 64'(ack[1] | err[1]), 64'd0);
    end
    cyc[1] = 1'b0;
    xfer(1, 1'b0, 16'd10, 4'hF, 32'h0, "rstw_rd", rd);

    // A write presented under reset must not be taken.
    keep = ref_mem[0][11];
    @(negedge clk);
    rst[0] = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'd11; sel[0] = 4'hF;
    wdat[0] = ~keep;
    @(negedge clk);
    check("rstreq_ack", 64'(ack[0]), 64'd0);
    stb[0] = 1'b0; cyc[0] = 1'b0; rst[0] = 1'b0;
    xfer(0, 1'b0, 16'd11, 4'hF, 32'h0, "rstreq_rd", rd);

    for (int n = 0; n < 120; n++) begin
      int d;
      d = n % 2;
      xfer(d, 1'($urandom_range(0, 1)), pick_addr(), 4'($urandom), $urandom, "rand", rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/wishbone_ram_target.md
WISHBONE_RAM_TARGET -- requirements
Module: wishbone_ram_target

Interface
REQ-001 Parameter AddressWidth, default 16: width of ADDR (word address).
REQ-002 Parameter DataWidth, default 32: data bus width in bits; one of 8, 16, 32 or 64.
REQ-003 Parameter Granularity, default 8: bits per select lane; SELWidth = DataWidth/Granularity.
REQ-004 Parameter Depth, default 1024: number of DataWidth-bit words stored; Depth <= 2**AddressWidth.
REQ-005 Parameter WaitStates, default 0: extra stall cycles per transfer; range 0..15.
REQ-006 CLK  input  1  single clock; all logic on rising edge.
REQ-007 RST  input  1  reset; synchronous, active-high.
REQ-008 CYC, STB, WE  input  1 each  Wishbone cycle, strobe and write enable.
REQ-009 ADDR  input  AddressWidth  word address.
REQ-010 SEL  input  SELWidth  lane write enables.
REQ-011 DAT_ToTarget  input  DataWidth  write data.
REQ-012 LOCK, CTI[2:0], BTE[1:0], TGA, TGC, TGD_ToTarget  input  per IWishbone  accepted and ignored.
REQ-013 DAT_ToInitiator  output  DataWidth  read data, valid only with ACK.
REQ-014 ACK, ERR, RTY, STALL  output  1 each  termination and flow control.
REQ-015 TGD_ToInitiator  output  TGDWidth  tied to 0.
REQ-016 The port set SHALL bind directly to the IWishbone Target modport plus CLK/RST.

Function
REQ-017 Pipelined Wishbone mode: request accepted in any cycle with CYC=1, STB=1, STALL=0.
REQ-018 States: IDLE, WAIT, RESP; STALL=1 only in WAIT.
REQ-019 Accept in IDLE or RESP: WaitStates=0 -> RESP next cycle; else WAIT with counter loaded to WaitStates-1.
REQ-020 WAIT: counter decrements each cycle; at 0 -> RESP next cycle.
REQ-021 RESP: ACK or ERR asserted exactly one cycle; new accept in same cycle follows REQ-019, otherwise -> IDLE.
REQ-022 Latency: accept at cycle t -> ACK/ERR at t+1+WaitStates; throughput one transfer per 1+WaitStates cycles.
REQ-023 Write commits at the accept clock edge; SEL[i]=1 updates lane i only; SEL=0 writes nothing but is still ACKed.
REQ-024 Read data sampled at the accept edge, after any same-edge write; held to response; SEL ignored for reads.
REQ-025 ADDR >= Depth: no memory access; ERR instead of ACK at the same cycle; DAT_ToInitiator=0.
REQ-026 DAT_ToInitiator=0 whenever ACK=0; after a write ACK it is 0.
REQ-027 ACK and ERR never both 1; exactly one termination per accepted request; RTY always 0.
REQ-028 CYC=0 in WAIT or RESP aborts: no ACK/ERR is issued; -> IDLE next cycle; committed writes remain.
REQ-029 STB=1 with CYC=0 SHALL be ignored.

Reset
REQ-030 RST=1 at a clock edge: state IDLE; counter 0; ACK=ERR=RTY=STALL=0; DAT_ToInitiator=0.
REQ-031 Reset mid-transfer discards the pending response; memory contents are not reset.
REQ-032 Requests presented while RST=1 are not accepted.

Verification
REQ-033 WaitStates=0: write ADDR=5, DAT=0xDEADBEEF, SEL=4'b1111 at t; read ADDR=5 at t+1 -> ACK at t+1 and t+2; second returns 0xDEADBEEF.
REQ-034 Byte lanes: word 5=0xDEADBEEF; write 0x11223344 with SEL=4'b0101; read -> 0xDE22BE44.
REQ-035 WaitStates=3: accept at t -> STALL=1 for t+1..t+3; ACK at t+4; next request accepted at t+4.
REQ-036 Depth=1024: read ADDR=1024 -> ERR one cycle after accept, ACK=0, DAT_ToInitiator=0; write ADDR=2000 changes no word.
REQ-037 WaitStates=2: write accepted, CYC dropped in WAIT -> no ACK/ERR; later read of that address returns the new data.
REQ-038 RST pulsed during WAIT -> outputs 0 next cycle; no ACK/ERR follows; earlier memory data is preserved.
